cache_prefetch: RTL and testbench

- Read-only, direct-mapped cache model with next-block-on-miss prefetch, used as a cache/prefetch reference block.
- Each lookup reports a registered hit flag and a 32-bit data word.
- No external memory port: line fills and prefetches complete in the same cycle as the miss, using a deterministic internal data pattern.

---
 rtl/cache_prefetch.sv | 116 +++++++++++
 tb/tb_cache_prefetch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cache_prefetch.sv
// ---------------------------------------------------------------------------
// cache_prefetch
//   Read-only, direct-mapped cache with next-block-on-miss prefetch.
//   There is no memory port. Demand fills and prefetch fills both complete
//   at the edge that detects the miss, and the line data is generated
//   internally: DA7A_0000 OR'd with the block base address.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset (clears valid bits
//                     and both outputs)
//   read_enable  in   lookup request, sampled at each rising edge
//   addr         in   [ADDR_WIDTH-1:0] lookup address, sampled with read_enable
//   hit          out  registered; 1 = the lookup at the previous edge hit
//   data_out     out  [31:0] registered; line data on a hit, 0 on a miss,
//                     held while read_enable is low
// ---------------------------------------------------------------------------
module cache_prefetch #(
   parameter int CACHE_SIZE = 16,
   parameter int BLOCK_SIZE = 4,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  hit,
   output logic [31:0]           data_out
);

   // OB = offset bits, IB = index bits, TB = tag bits, BW = block-number width
   localparam int OB = $clog2(BLOCK_SIZE);
   localparam int IB = $clog2(CACHE_SIZE);
   localparam int BW = ADDR_WIDTH - OB;
   localparam int TB = BW - IB;

   // Fill pattern: the block base address in the low bits under a fixed tag.
   function automatic logic [31:0] fill_data(input logic [BW-1:0] blk);
      logic [ADDR_WIDTH-1:0] base;
      base = ADDR_WIDTH'(blk) << OB;
      return 32'hDA7A_0000 | 32'(base);
   endfunction

   // Line storage. Only the valid bits are reset; tag and data are
   // meaningless while valid is clear.
   logic [CACHE_SIZE-1:0] r_valid;
   logic [TB-1:0]         r_tag  [CACHE_SIZE];
   logic [31:0]           r_data [CACHE_SIZE];

   logic                  r_hit;
   logic [31:0]           r_data_out;

   // Address decode for the demand block and for the next sequential block.
   logic [BW-1:0]         w_blk;
   logic [BW-1:0]         w_nblk;
   logic [IB-1:0]         w_idx;
   logic [TB-1:0]         w_tag;
   logic [IB-1:0]         w_nidx;
   logic [TB-1:0]         w_ntag;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_unused_ofs;

   // The offset takes no part in a lookup. It is folded into a sink so the
   // whole address bus stays visibly consumed.
   assign w_unused_ofs = ^addr;

   assign w_blk  = addr[ADDR_WIDTH-1:OB];
   assign w_nblk = w_blk + 1'b1;            // wraps mod 2^BW
   assign w_idx  = w_blk[IB-1:0];
   assign w_tag  = w_blk[BW-1:IB];
   assign w_nidx = w_nblk[IB-1:0];
   assign w_ntag = w_nblk[BW-1:IB];

   assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_miss = read_enable && !w_hit;

   // Valid bits and output registers. The lookup uses the pre-edge state.
   // On a miss, the demand line and the next-block line are marked valid at
   // the same edge. The two indices always differ because CACHE_SIZE >= 2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= '0;
         r_hit      <= 1'b0;
         r_data_out <= '0;
      end else if (read_enable) begin
         if (w_hit) begin
            r_hit      <= 1'b1;
            r_data_out <= r_data[w_idx];
         end else begin
            r_hit           <= 1'b0;
            r_data_out      <= '0;
            r_valid[w_idx]  <= 1'b1;
            r_valid[w_nidx] <= 1'b1;
         end
      end else begin
         // Idle edge: hit drops, data_out keeps the last value.
         r_hit <= 1'b0;
      end
   end

   // Tag and data arrays have no reset. A write during reset is harmless
   // because the matching valid bit is held clear.
   always_ff @(posedge clk) begin
      if (w_miss) begin
         r_tag[w_idx]   <= w_tag;
         r_data[w_idx]  <= fill_data(w_blk);
         r_tag[w_nidx]  <= w_ntag;
         r_data[w_nidx] <= fill_data(w_nblk);
      end
   end

   assign hit      = r_hit;
   assign data_out = r_data_out;

endmodule

// File: tb/tb_cache_prefetch.sv
// ---------------------------------------------------------------------------
// tb_cache_prefetch
//   Table-driven bench for cache_prefetch with the default parameters
//   (16 lines, 4 addresses per block, 8-bit address). Each table row drives
//   one clock edge, and its expected result is queued when the row is
//   driven. The result is popped and compared 1 ns after that edge.
//   Hand-written sequences cover the reset state and an asynchronous reset
//   taken in the middle of a run.
// ---------------------------------------------------------------------------
module tb_cache_prefetch;

   typedef struct {
      logic        rst;
      logic        re;
      logic [7:0]  addr;
      logic        exp_hit;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic        hit;
      logic [31:0] data;
      int          row;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        read_enable;
   logic [7:0]  addr;
   logic        hit;
   logic [31:0] data_out;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   cache_prefetch #(.CACHE_SIZE(16), .BLOCK_SIZE(4), .ADDR_WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .read_enable (read_enable),
      .addr        (addr),
      .hit         (hit),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   task automatic check_now(input string nm, input logic a_hit, input logic [31:0] a_data,
                            input logic e_hit, input logic [31:0] e_data);
      checks++;
      if (a_hit !== e_hit || a_data !== e_data) begin
         errors++;
         $display("FAIL %s: got hit=%b data=%h, want hit=%b data=%h",
                  nm, a_hit, a_data, e_hit, e_data);
      end
   endtask

   // Drive a row at the falling edge, queue its expectation, then compare
   // after the next rising edge.
   task automatic apply(input vec_t v, input int row);
      exp_t e;
      @(negedge clk);
      reset       = v.rst;
      read_enable = v.re;
      addr        = v.addr;
      e.hit  = v.exp_hit;
      e.data = v.exp_data;
      e.row  = row;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty row %0d", row);
      end else begin
         e = sb.pop_front();
         check_now($sformatf("row%0d addr=%h", e.row, v.addr), hit, data_out, e.hit, e.data);
      end
   endtask

   vec_t vecs[23];

   initial begin
      // rst, re, addr, exp_hit, exp_data
      vecs[0]  = '{1'b0, 1'b1, 8'h10, 1'b0, 32'h0};           // cold miss, prefetches 0x14
      vecs[1]  = '{1'b0, 1'b1, 8'h10, 1'b1, 32'hDA7A0010};    // held address now hits
      vecs[2]  = '{1'b0, 1'b1, 8'h14, 1'b1, 32'hDA7A0014};    // prefetched block
      vecs[3]  = '{1'b0, 1'b1, 8'h12, 1'b1, 32'hDA7A0010};    // offset ignored
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'hDA7A0010};    // idle edge: data held
      vecs[5]  = '{1'b0, 1'b1, 8'h13, 1'b1, 32'hDA7A0010};    // still resident after idle
      vecs[6]  = '{1'b0, 1'b1, 8'h50, 1'b0, 32'h0};           // conflicts with 0x10, prefetch 0x54 evicts 0x14
      vecs[7]  = '{1'b0, 1'b1, 8'h10, 1'b0, 32'h0};           // evicted, refill re-prefetches 0x14
      vecs[8]  = '{1'b0, 1'b1, 8'h14, 1'b1, 32'hDA7A0014};
      vecs[9]  = '{1'b0, 1'b1, 8'h50, 1'b0, 32'h0};           // evict both again
      vecs[10] = '{1'b0, 1'b1, 8'h14, 1'b0, 32'h0};           // other order: 0x14 first
      vecs[11] = '{1'b0, 1'b1, 8'h10, 1'b0, 32'h0};           // line 4 still holds 0x50
      vecs[12] = '{1'b0, 1'b1, 8'h54, 1'b0, 32'h0};           // 0x10 miss re-prefetched 0x14
      vecs[13] = '{1'b0, 1'b1, 8'h50, 1'b0, 32'h0};           // line 4 holds 0x10, miss
      vecs[14] = '{1'b0, 1'b1, 8'h54, 1'b1, 32'hDA7A0054};
      vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0};           // reset for a fresh cache
      vecs[16] = '{1'b0, 1'b1, 8'hFC, 1'b0, 32'h0};           // top block, prefetch wraps to 0
      vecs[17] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'hDA7A0000};
      vecs[18] = '{1'b0, 1'b1, 8'hFE, 1'b1, 32'hDA7A00FC};
      vecs[19] = '{1'b0, 1'b1, 8'h03, 1'b1, 32'hDA7A0000};
      vecs[20] = '{1'b0, 1'b0, 8'hFC, 1'b0, 32'hDA7A0000};    // idle edge after a hit
      vecs[21] = '{1'b0, 1'b1, 8'h04, 1'b0, 32'h0};           // block 1 not resident
      vecs[22] = '{1'b0, 1'b1, 8'h08, 1'b1, 32'hDA7A0008};    // block 2 was prefetched

      // Reset state: outputs are cleared while reset is held.
      reset       = 1'b1;
      read_enable = 1'b0;
      addr        = 8'h00;
      #19;
      check_now("reset_state", hit, data_out, 1'b0, 32'h0);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 23; i++) apply(vecs[i], i);

      // The last row left hit=1. Raising reset between edges must clear the
      // outputs at once, before any clock edge.
      check_now("pre_async_hit", hit, data_out, 1'b1, 32'hDA7A0008);
      @(negedge clk);
      reset       = 1'b1;
      read_enable = 1'b1;
      addr        = 8'h08;
      #1;
      check_now("async_reset_immediate", hit, data_out, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      check_now("async_reset_held", hit, data_out, 1'b0, 32'h0);

      // After release, previously resident blocks miss.
      apply('{1'b0, 1'b1, 8'h10, 1'b0, 32'h0}, 100);
      apply('{1'b0, 1'b1, 8'h10, 1'b1, 32'hDA7A0010}, 101);
      apply('{1'b0, 1'b1, 8'h08, 1'b0, 32'h0}, 102);

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety bound in case the run stalls.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
